// File: rtl/cnn_layer_accel_conv_job_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cnn_layer_accel_conv_job_engine                              |
// | Description : Job-driven per-lane sliding-window (box) convolver with      |
// |               optional ReLU. Define CNN_CONV_JOB_STATS_EN for stall_count. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cnn_layer_accel_conv_job_engine #(
   parameter int C_NUM_LANES    = 8,
   parameter int C_PIXEL_WIDTH  = 16,
   parameter int C_MAX_WINDOW   = 7,
   parameter int C_OPCODE_WIDTH = 64,
   parameter int C_RESULT_WIDTH = C_PIXEL_WIDTH + $clog2(C_MAX_WINDOW)
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [C_OPCODE_WIDTH-1:0]               opcode,
   input  logic                                    opcode_valid,
   output logic                                    opcode_accept,
   output logic                                    opcode_error,
   output logic                                    opcode_complete,
   input  logic [C_NUM_LANES*C_PIXEL_WIDTH-1:0]    datain,
   input  logic                                    datain_valid,
   output logic                                    datain_ready,
   output logic [C_NUM_LANES*C_RESULT_WIDTH-1:0]   dataout,
   output logic                                    dataout_valid,
   input  logic                                    dataout_ready
`ifdef CNN_CONV_JOB_STATS_EN
   ,
   output logic [31:0]                             stall_count
`endif
);

   localparam int W = C_PIXEL_WIDTH;
   localparam int R = C_RESULT_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_BUSY   = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t                                         state_q, state_d;
   logic [15:0]                                    n_q, n_d;
   logic [3:0]                                     k_q, k_d;
   logic                                           relu_q, relu_d;
   logic [15:0]                                    cnt_q, cnt_d;
   logic [C_NUM_LANES-1:0][C_MAX_WINDOW-1:0][W-1:0] win_q, win_d;
   logic [C_NUM_LANES-1:0][R-1:0]                  sum_q, sum_d;
   logic [C_NUM_LANES*R-1:0]                       dataout_q, dataout_d;
   logic                                           dataout_valid_q, dataout_valid_d;
   logic                                           accept_q, accept_d;
   logic                                           error_q, error_d;
   logic                                           complete_q, complete_d;

   logic [C_NUM_LANES-1:0][C_MAX_WINDOW-1:0][W-1:0] win_shift;
   logic [C_NUM_LANES-1:0][R-1:0]                  sum_new;
   logic [C_NUM_LANES-1:0][R-1:0]                  lane_res;
   logic [15:0]                                    op_n;
   logic [3:0]                                     op_k;
   logic                                           op_legal;
   logic                                           beat;
   logic [16:0]                                    cnt_next;
   logic [C_OPCODE_WIDTH-22:0]                     unused_opcode_bits;

   assign op_n               = opcode[15:0];
   assign op_k               = opcode[19:16];
   assign unused_opcode_bits = {opcode[C_OPCODE_WIDTH-1:25], opcode[23:20]};
   assign op_legal           = (op_k != 4'd0) && (32'(op_k) <= C_MAX_WINDOW) &&
                               ({12'd0, op_k} <= op_n);

   assign datain_ready = (state_q == S_BUSY) && (!dataout_valid_q || dataout_ready);
   assign beat         = datain_valid && datain_ready;
   assign cnt_next     = {1'b0, cnt_q} + 17'd1;

   // Window entry j holds the sample taken j+1 beats ago, so entry K-1 leaves the sum.
   for (genvar l = 0; l < C_NUM_LANES; l++) begin : g_lane
      logic [R-1:0] x_ext;
      logic [R-1:0] oldest;

      assign x_ext = {{(R-W){datain[l*W+W-1]}}, datain[l*W +: W]};

      always_comb begin
         oldest = '0;
         for (int j = 0; j < C_MAX_WINDOW; j++) begin
            if (j + 1 == 32'(k_q)) begin
               oldest = {{(R-W){win_q[l][j][W-1]}}, win_q[l][j]};
            end
         end
      end

      assign win_shift[l] = {win_q[l][C_MAX_WINDOW-2:0], datain[l*W +: W]};
      assign sum_new[l]   = sum_q[l] + x_ext - oldest;
      assign lane_res[l]  = (relu_q && sum_new[l][R-1]) ? '0 : sum_new[l];
   end

   always_comb begin
      state_d         = state_q;
      n_d             = n_q;
      k_d             = k_q;
      relu_d          = relu_q;
      cnt_d           = cnt_q;
      win_d           = win_q;
      sum_d           = sum_q;
      dataout_d       = dataout_q;
      dataout_valid_d = dataout_valid_q;
      accept_d        = 1'b0;
      error_d         = 1'b0;
      complete_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (opcode_valid) begin
               n_d      = op_n;
               k_d      = op_k;
               relu_d   = opcode[24];
               accept_d = 1'b1;
               error_d  = !op_legal;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            if (error_q) begin
               state_d = S_IDLE;
            end else begin
               cnt_d   = '0;
               win_d   = '0;
               sum_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (dataout_ready) begin
               dataout_valid_d = 1'b0;
            end
            if (beat) begin
               win_d = win_shift;
               sum_d = sum_new;
               cnt_d = cnt_next[15:0];
               if (cnt_next >= {13'd0, k_q}) begin
                  dataout_d       = lane_res;
                  dataout_valid_d = 1'b1;
               end
               if (cnt_next == {1'b0, n_q}) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (dataout_valid_q && dataout_ready) begin
               dataout_valid_d = 1'b0;
               complete_d      = 1'b1;
               state_d         = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef CNN_CONV_JOB_STATS_EN
   logic [31:0] stall_q, stall_d;
   logic        stall_cycle;

   assign stall_cycle = ((state_q == S_BUSY) &&
                         (!datain_valid || (dataout_valid_q && !dataout_ready))) ||
                        ((state_q == S_DRAIN) && dataout_valid_q && !dataout_ready);

   always_comb begin
      stall_d = stall_q;
      if (state_q == S_DECODE && !error_q) begin
         stall_d = '0;
      end else if (stall_cycle && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   assign stall_count = stall_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         n_q             <= '0;
         k_q             <= '0;
         relu_q          <= 1'b0;
         cnt_q           <= '0;
         win_q           <= '0;
         sum_q           <= '0;
         dataout_q       <= '0;
         dataout_valid_q <= 1'b0;
         accept_q        <= 1'b0;
         error_q         <= 1'b0;
         complete_q      <= 1'b0;
`ifdef CNN_CONV_JOB_STATS_EN
         stall_q         <= '0;
`endif
      end else begin
         state_q         <= state_d;
         n_q             <= n_d;
         k_q             <= k_d;
         relu_q          <= relu_d;
         cnt_q           <= cnt_d;
         win_q           <= win_d;
         sum_q           <= sum_d;
         dataout_q       <= dataout_d;
         dataout_valid_q <= dataout_valid_d;
         accept_q        <= accept_d;
         error_q         <= error_d;
         complete_q      <= complete_d;
`ifdef CNN_CONV_JOB_STATS_EN
         stall_q         <= stall_d;
`endif
      end
   end

   assign opcode_accept   = accept_q;
   assign opcode_error    = error_q;
   assign opcode_complete = complete_q;
   assign dataout         = dataout_q;
   assign dataout_valid   = dataout_valid_q;

endmodule
`default_nettype wire
